r_station_queue: RTL and testbench

Parametrised multi-entry reservation station between instruction decode and the execute scheduler. It buffers up to DEPTH decoded micro-op bundles, each with up to MAX_UOPS micro-ops and one K_W-bit operand, and issues micro-ops one per scheduler acknowledge in program order. Each bundle's operand can be overwritten by memory data while the bundle is at the head. A flush input discards all buffered work in one cycle.

---
 rtl/r_station_queue.sv | 142 ++++++++++++++
 tb/tb_r_station_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_station_queue.sv
// r_station_queue: DEPTH-entry reservation station between decode and the
// execute scheduler. Holds bundles of up to MAX_UOPS micro-ops plus one
// K_W-bit operand and issues one micro-op per scheduler acknowledge, in order.
// The head operand can be overwritten by load data; flush empties the station.
// Optional build macro: RSQ_BYPASS_EN forwards mem_data_in onto ex_data_out
// in the same cycle as mem_data_wr (storage behaviour is unchanged).
module r_station_queue #(
  parameter int UOP_W    = 20,
  parameter int K_W      = 16,
  parameter int MAX_UOPS = 3,
  parameter int DEPTH    = 2,
  parameter logic [UOP_W-1:0] NOP = 20'b0000_0000_1111_00_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              id_feed_req,
  input  logic                              id_feed_ack,
  input  logic [UOP_W*MAX_UOPS-1:0]         id_uops,
  input  logic [$clog2(MAX_UOPS+1)-1:0]     id_uop_count,
  input  logic [K_W-1:0]                    id_k16,
  output logic [UOP_W-1:0]                  ex_uop_next,
  output logic                              ex_uop_last,
  output logic                              ex_is_valid,
  input  logic                              ex_sched_ack,
  input  logic [K_W-1:0]                    mem_data_in,
  input  logic                              mem_data_wr,
  output logic [K_W-1:0]                    ex_data_out,
  input  logic                              flush,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);
  localparam int CW = $clog2(MAX_UOPS+1);
  localparam int OW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  // Entry storage and control state
  logic [UOP_W-1:0] uops_q [DEPTH][MAX_UOPS];
  logic [UOP_W-1:0] uops_d [DEPTH][MAX_UOPS];
  logic [CW-1:0]    cnt_q  [DEPTH];
  logic [CW-1:0]    cnt_d  [DEPTH];
  logic [K_W-1:0]   k_q    [DEPTH];
  logic [K_W-1:0]   k_d    [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    idx_q, idx_d;

  logic [UOP_W-1:0] id_slot [MAX_UOPS];
  logic [CW-1:0]    cnt_in;
  logic [CW-1:0]    head_cnt;
  logic             valid, last, issue, retire, push;

  // Split the incoming bundle into its micro-op slots (slot 0 in low bits)
  for (genvar gi = 0; gi < MAX_UOPS; gi++) begin : g_slot
    assign id_slot[gi] = id_uops[gi*UOP_W +: UOP_W];
  end

  // Handshake decode: clamp count, head status, issue/retire/push qualifiers
  always_comb begin
    if ({1'b0, id_uop_count} > (CW+1)'(MAX_UOPS)) cnt_in = CW'(MAX_UOPS);
    else                                           cnt_in = id_uop_count;
    head_cnt    = cnt_q[rd_q];
    valid       = (occ_q != '0);
    last        = valid && ((idx_q + CW'(1)) == head_cnt);
    issue       = ex_sched_ack & valid;
    retire      = issue & last;
    // Retire frees a slot this cycle, so a full station may still accept.
    id_feed_req = ~flush & ((occ_q < OW'(DEPTH)) | retire);
    // A zero-count bundle consumes the ack but stores nothing.
    push        = id_feed_ack & id_feed_req & (cnt_in != '0);
  end

  // Head-facing outputs
  assign ex_is_valid = valid;
  assign ex_uop_last = last;
  assign ex_uop_next = valid ? uops_q[rd_q][idx_q] : NOP;
  assign occupancy   = occ_q;
`ifdef RSQ_BYPASS_EN
  assign ex_data_out = (mem_data_wr & valid) ? mem_data_in : (valid ? k_q[rd_q] : '0);
`else
  assign ex_data_out = valid ? k_q[rd_q] : '0;
`endif

  // Next-state: load write, issue/retire, push, occupancy; flush overrides all
  always_comb begin
    uops_d = uops_q;
    cnt_d  = cnt_q;
    k_d    = k_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    occ_d  = occ_q;
    idx_d  = idx_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
      idx_d = '0;
    end else begin
      // Load data goes to the head; if the head retires now, it is simply lost.
      if (mem_data_wr && valid) k_d[rd_q] = mem_data_in;
      if (issue) begin
        if (retire) begin
          idx_d = '0;
          rd_d  = rd_q + PW'(1);
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      // Push last so that a refill of the retiring slot at full wins.
      if (push) begin
        for (int s = 0; s < MAX_UOPS; s++) uops_d[wr_q][s] = id_slot[s];
        cnt_d[wr_q] = cnt_in;
        k_d[wr_q]   = id_k16;
        wr_d        = wr_q + PW'(1);
      end
      if (push && !retire)      occ_d = occ_q + OW'(1);
      else if (!push && retire) occ_d = occ_q - OW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int s = 0; s < MAX_UOPS; s++) uops_q[e][s] <= '0;
        cnt_q[e] <= '0;
        k_q[e]   <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      idx_q <= '0;
    end else begin
      uops_q <= uops_d;
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: tb/tb_r_station_queue.sv
// tb_r_station_queue: directed test-plan scenarios followed by random traffic,
// every cycle compared against a queue-of-bundles reference model.
module tb_r_station_queue;
  localparam int UOP_W    = 20;
  localparam int K_W      = 16;
  localparam int MAX_UOPS = 3;
  localparam int DEPTH    = 2;
  localparam logic [UOP_W-1:0] NOP = 20'b0000_0000_1111_00_000_000;
  localparam int CW = $clog2(MAX_UOPS+1);
  localparam int OW = $clog2(DEPTH+1);

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      id_feed_req;
  logic                      id_feed_ack;
  logic [UOP_W*MAX_UOPS-1:0] id_uops;
  logic [CW-1:0]             id_uop_count;
  logic [K_W-1:0]            id_k16;
  logic [UOP_W-1:0]          ex_uop_next;
  logic                      ex_uop_last;
  logic                      ex_is_valid;
  logic                      ex_sched_ack;
  logic [K_W-1:0]            mem_data_in;
  logic                      mem_data_wr;
  logic [K_W-1:0]            ex_data_out;
  logic                      flush;
  logic [OW-1:0]             occupancy;

  always #5 clk = ~clk;

  r_station_queue #(
    .UOP_W(UOP_W), .K_W(K_W), .MAX_UOPS(MAX_UOPS), .DEPTH(DEPTH), .NOP(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .id_feed_req(id_feed_req), .id_feed_ack(id_feed_ack),
    .id_uops(id_uops), .id_uop_count(id_uop_count), .id_k16(id_k16),
    .ex_uop_next(ex_uop_next), .ex_uop_last(ex_uop_last), .ex_is_valid(ex_is_valid),
    .ex_sched_ack(ex_sched_ack),
    .mem_data_in(mem_data_in), .mem_data_wr(mem_data_wr), .ex_data_out(ex_data_out),
    .flush(flush), .occupancy(occupancy)
  );

  // Reference model: an ordered list of buffered bundles plus the head index.
  typedef struct packed {
    logic [UOP_W*MAX_UOPS-1:0] u;
    int                        cnt;
    logic [K_W-1:0]            k;
  } bundle_t;

  bundle_t mq[$];
  int      midx = 0;
  int      n_cmp = 0;
  int      n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs derived from the model for the current inputs
  task automatic check_outputs();
    bundle_t          h;
    logic             e_valid, e_last, e_req;
    logic [UOP_W-1:0] e_uop;
    logic [K_W-1:0]   e_k;
    e_valid = (mq.size() != 0);
    e_uop   = NOP;
    e_last  = 1'b0;
    e_k     = '0;
    if (e_valid) begin
      h      = mq[0];
      e_uop  = h.u[midx*UOP_W +: UOP_W];
      e_last = (midx == h.cnt - 1);
      e_k    = h.k;
    end
`ifdef RSQ_BYPASS_EN
    if (mem_data_wr && e_valid) e_k = mem_data_in;
`endif
    e_req = !flush && ((mq.size() < DEPTH) || (ex_sched_ack && e_valid && e_last));
    chk("valid", ex_is_valid, e_valid);
    chk("uop", ex_uop_next, e_uop);
    chk("last", ex_uop_last, e_last);
    chk("data", ex_data_out, e_k);
    chk("feed_req", id_feed_req, e_req);
    chk("occupancy", occupancy, mq.size());
  endtask

  // Apply one clock edge to the model, using the inputs held across the edge
  task automatic model_update();
    bundle_t h, nb;
    int      sz0;
    bit      ret;
    if (rst || flush) begin
      if (mq.size() != 0 || midx != 0) $display("%s: station emptied", rst ? "reset" : "flush");
      mq.delete();
      midx = 0;
      return;
    end
    sz0 = mq.size();
    ret = 0;
    if (sz0 != 0) begin
      h = mq[0];
      if (mem_data_wr) begin
        h.k   = mem_data_in;
        mq[0] = h;
      end
      if (ex_sched_ack) begin
        $display("issue uop=%05h last=%0d", h.u[midx*UOP_W +: UOP_W], midx == h.cnt - 1);
        if (midx == h.cnt - 1) begin
          void'(mq.pop_front());
          midx = 0;
          ret  = 1;
        end else begin
          midx++;
        end
      end
    end
    if (id_feed_ack && (sz0 < DEPTH || ret) && id_uop_count != 0) begin
      nb.u   = id_uops;
      nb.cnt = (int'(id_uop_count) > MAX_UOPS) ? MAX_UOPS : int'(id_uop_count);
      nb.k   = id_k16;
      mq.push_back(nb);
      $display("push cnt=%0d k=%04h", nb.cnt, nb.k);
    end
  endtask

  // One cycle: inputs already driven after the falling edge
  task automatic step();
    #1;
    if (!rst) check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; id_feed_ack = 0; id_uops = '0; id_uop_count = '0; id_k16 = '0;
    ex_sched_ack = 0; mem_data_in = '0; mem_data_wr = 0; flush = 0;
  endtask

  task automatic set_push(input int cnt, input logic [K_W-1:0] k);
    id_feed_ack  = 1;
    id_uop_count = CW'(cnt);
    id_k16       = k;
    for (int s = 0; s < MAX_UOPS; s++) id_uops[s*UOP_W +: UOP_W] = UOP_W'($urandom);
  endtask

  task automatic drain();
    idle();
    ex_sched_ack = 1;
    for (int i = 0; i < 16 && mq.size() != 0; i++) step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;

    // Reset state
    #1;
    chk("rst_req", id_feed_req, 1);
    chk("rst_valid", ex_is_valid, 0);
    chk("rst_uop", ex_uop_next, NOP);
    chk("rst_data", ex_data_out, 0);
    step();

    // {A,B,C}, k=0x1234, scheduler always acking
    set_push(3, 16'h1234);
    id_uops = {20'hCCCCC, 20'hBBBBB, 20'hAAAAA};
    ex_sched_ack = 1;
    step();
    id_feed_ack = 0;
    #1;
    chk("abc_first", ex_uop_next, 20'hAAAAA);
    chk("abc_k", ex_data_out, 16'h1234);
    step(); step();
    #1;
    chk("abc_c_last", ex_uop_last, 1);
    step();
    #1;
    chk("abc_empty_uop", ex_uop_next, NOP);
    step();

    // Fill to full with one-uop bundles, refused, then accepted alongside a retire
    idle();
    set_push(1, 16'h0011); step();
    set_push(1, 16'h0022); step();
    set_push(1, 16'h0033);
    #1;
    chk("full_req", id_feed_req, 0);
    chk("full_occ", occupancy, 2);
    step();
    ex_sched_ack = 1;
    #1;
    chk("full_ack_req", id_feed_req, 1);
    step();
    idle();
    #1;
    chk("refill_occ", occupancy, 2);
    step();
    drain();

    // Load data overwriting the head operand while its first uop issues
    set_push(2, 16'h0001); step();
    idle();
    ex_sched_ack = 1; mem_data_wr = 1; mem_data_in = 16'hBEEF;
`ifdef RSQ_BYPASS_EN
    #1;
    chk("bypass_same", ex_data_out, 16'hBEEF);
`endif
    step();
    mem_data_wr = 0;
    #1;
    chk("load_next", ex_data_out, 16'hBEEF);
    step();
    drain();

    // Zero-count push, then largest representable count
    set_push(0, 16'h5555); step();
    idle();
    #1;
    chk("zero_push_occ", occupancy, 0);
    step();
    set_push((1 << CW) - 1, 16'h6666); step();
    drain();

    // Two bundles buffered, mid-bundle flush with push and load write
    set_push(2, 16'h0101); step();
    set_push(2, 16'h0202); step();
    idle(); ex_sched_ack = 1; step();
    idle(); flush = 1; mem_data_wr = 1; mem_data_in = 16'h7777;
    set_push(3, 16'h0303); step();
    idle();
    #1;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", ex_is_valid, 0);
    chk("flush_uop", ex_uop_next, NOP);
    step();

    // Reset mid-issue, then a fresh bundle issues from slot 0
    set_push(3, 16'h0404); step();
    idle(); ex_sched_ack = 1; step();
    idle(); rst = 1; ex_sched_ack = 1; step();
    idle();
    #1;
    chk("rst_mid_occ", occupancy, 0);
    chk("rst_mid_req", id_feed_req, 1);
    step();
    set_push(2, 16'h0505);
    id_uops[UOP_W-1:0] = 20'h12345;
    step();
    idle();
    #1;
    chk("rst_slot0", ex_uop_next, 20'h12345);
    step();
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      rst          = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 29) == 0);
      ex_sched_ack = ($urandom_range(0, 99) < 60);
      mem_data_wr  = ($urandom_range(0, 3) == 0);
      mem_data_in  = K_W'($urandom);
      if ($urandom_range(0, 99) < 55)
        set_push($urandom_range(0, (1 << CW) - 1), K_W'($urandom));
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
